main_ctrl_fsm: RTL

Multicycle main control FSM for the RV32I core. Sequences the shared datapath per instruction: memory, IR, PC, register file, ALU operand muxes. Drives `alu_op` into the ALU decoder, which turns it into the 3-bit ALU control. Holds on a simple memory ready handshake.

---
 rtl/riscv_ctrl_pkg.sv | 57 +++++
 rtl/main_ctrl_fsm_imm_src_dec.sv | 22 ++
 rtl/main_ctrl_fsm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RV32I multicycle core.
// Holds the main-FSM state enum, the supported opcode constants and the
// encodings of the datapath select fields (alu_src_a, alu_src_b,
// result_src, alu_op, imm_src). The ALU decoder and the single-cycle
// core import the same constants so all encodings stay in one place.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // Operand B select
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU decoder operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/main_ctrl_fsm_imm_src_dec.sv
// imm_src_dec: combinational opcode -> immediate-format decoder.
// Shared between the multicycle controller and the single-cycle core.
// Ports:
//   op      in  7  instr[6:0]
//   imm_src out 2  immediate format (I/S/B/J)
module imm_src_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// main_ctrl_fsm: multicycle main control FSM for the RV32I core.
// Sequences memory, IR, PC, register file and ALU operand muxes per
// instruction and stalls in FETCH/MEMREAD/MEMWRITE until mem_ready.
// Optional feature macro: MAIN_CTRL_ILLEGAL_TRAP_EN -- when defined, an
// unsupported opcode parks the FSM in HALT with a sticky illegal flag;
// otherwise such an opcode is a 2-cycle NOP and illegal is tied low.
// Ports:
//   clk, rst_n (sync active-low)  op[6:0], zero, mem_ready  (inputs)
//   mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
//   alu_src_a[1:0], alu_src_b[1:0], result_src[1:0], alu_op[1:0],
//   imm_src[1:0], instr_done, illegal                     (outputs)
module main_ctrl_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal
);

    state_t state_reg;
    state_t state_next;
    state_t dec_state;
    // op is only looked at in DECODE; remember lw vs sw for MEMADR.
    logic   is_store_reg;

    logic mem_req_raw, mem_write_raw, ir_write_raw, reg_write_raw;
    logic instr_done_raw, pc_update, pc_write_raw;

    imm_src_dec u_imm_src_dec (
        .op      (op),
        .imm_src (imm_src)
    );

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
                    default:      state_next = S_HALT;
`else
                    default:      state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_next = is_store_reg ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
            S_HALT:     state_next = S_HALT;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

    // State register and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_FETCH;
            is_store_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                is_store_reg <= (op == OP_SW);
        end
    end

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    logic illegal_reg;
    always_ff @(posedge clk) begin
        if (!rst_n)
            illegal_reg <= 1'b0;
        else if (state_next == S_HALT)
            illegal_reg <= 1'b1;
    end
    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

    // While in reset, selects show their FETCH values.
    assign dec_state = rst_n ? state_reg : S_FETCH;

    // Moore output decode
    always_comb begin
        mem_req_raw    = 1'b0;
        mem_write_raw  = 1'b0;
        adr_src        = 1'b0;
        ir_write_raw   = 1'b0;
        reg_write_raw  = 1'b0;
        instr_done_raw = 1'b0;
        pc_update      = 1'b0;
        alu_src_a      = SRCA_PC;
        alu_src_b      = SRCB_RD2;
        result_src     = RES_ALUOUT;
        alu_op         = ALUOP_ADD;
        case (dec_state)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                ir_write_raw = mem_ready;
                pc_update    = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src     = RES_DATA;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_raw    = 1'b1;
                mem_write_raw  = 1'b1;
                adr_src        = 1'b1;
                instr_done_raw = mem_ready;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a      = SRCA_RD1;
                alu_op         = ALUOP_SUB;
                instr_done_raw = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // FETCH only advances the PC once memory delivers the instruction.
    assign pc_write_raw = (pc_update && (dec_state != S_FETCH || mem_ready))
                        || (dec_state == S_BEQ && zero);

    assign mem_req    = rst_n & mem_req_raw;
    assign mem_write  = rst_n & mem_write_raw;
    assign ir_write   = rst_n & ir_write_raw;
    assign pc_write   = rst_n & pc_write_raw;
    assign reg_write  = rst_n & reg_write_raw;
    assign instr_done = rst_n & instr_done_raw;

endmodule
